mist1032sa_mem_access_master: RTL and testbench

//  Initiator for the sim memory REQ/LOCK/VALID interface. Converts core byte/half/word load-store

---
 rtl/mist1032sa_mem_pkg.sv | 43 ++++
 rtl/mist1032sa_mem_access_master_if.sv | 40 ++++
 rtl/mist1032sa_mem_tag_fifo.sv | 62 ++++++
 rtl/mist1032sa_mem_access_master.sv | 136 +++++++++++++
 tb/tb_mist1032sa_mem_access_master.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mist1032sa_mem_pkg.sv
// Shared widths, order encodings, read-tag layout and load extraction for the
// sim-memory access master.
package mist1032sa_mem_pkg;

  localparam int unsigned ADDR_W = 26;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LINE_W = 64;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned TAG_W  = 3 + 2 + 1;

  localparam logic [1:0] ORDER_BYTE = 2'b00;
  localparam logic [1:0] ORDER_HALF = 2'b01;
  localparam logic [1:0] ORDER_WORD = 2'b10;
  localparam logic [1:0] ORDER_NONE = 2'b11;

  typedef struct packed {
    logic [2:0] addr;
    logic [1:0] order;
    logic       sgn;
  } tag_t;

  // Select the addressed word, then the byte/half lane, then extend to 32 bits.
  function automatic logic [DATA_W-1:0] extract_load(input logic [LINE_W-1:0] line,
                                                     input tag_t tag);
    logic [31:0] word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    word = tag.addr[2] ? line[63:32] : line[31:0];
    case (tag.addr[1:0])
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = tag.addr[1] ? word[31:16] : word[15:0];
    case (tag.order)
      ORDER_BYTE: extract_load = tag.sgn ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      ORDER_HALF: extract_load = tag.sgn ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      default:    extract_load = word;
    endcase
  endfunction

endpackage

// File: rtl/mist1032sa_mem_access_master_if.sv
// Core-side and memory-side signal bundle of the access master.
interface mist1032sa_mem_access_master_if;
  import mist1032sa_mem_pkg::*;

  logic              iCORE_REQ;
  logic              oCORE_BUSY;
  logic [1:0]        iCORE_ORDER;
  logic              iCORE_RW;
  logic              iCORE_SIGNED;
  logic [ADDR_W-1:0] iCORE_ADDR;
  logic [DATA_W-1:0] iCORE_DATA;
  logic              oCORE_VALID;
  logic              iCORE_BUSY;
  logic [DATA_W-1:0] oCORE_DATA;
  logic              oMEMORY_REQ;
  logic              iMEMORY_LOCK;
  logic [1:0]        oMEMORY_ORDER;
  logic [MASK_W-1:0] oMEMORY_MASK;
  logic              oMEMORY_RW;
  logic [ADDR_W-1:0] oMEMORY_ADDR;
  logic [DATA_W-1:0] oMEMORY_DATA;
  logic              iMEMORY_VALID;
  logic              oMEMORY_LOCK;
  logic [LINE_W-1:0] iMEMORY_DATA;

  modport master (
    input  iCORE_REQ, iCORE_ORDER, iCORE_RW, iCORE_SIGNED, iCORE_ADDR, iCORE_DATA, iCORE_BUSY,
           iMEMORY_LOCK, iMEMORY_VALID, iMEMORY_DATA,
    output oCORE_BUSY, oCORE_VALID, oCORE_DATA, oMEMORY_REQ, oMEMORY_ORDER, oMEMORY_MASK,
           oMEMORY_RW, oMEMORY_ADDR, oMEMORY_DATA, oMEMORY_LOCK
  );

  modport slave (
    output iCORE_REQ, iCORE_ORDER, iCORE_RW, iCORE_SIGNED, iCORE_ADDR, iCORE_DATA, iCORE_BUSY,
           iMEMORY_LOCK, iMEMORY_VALID, iMEMORY_DATA,
    input  oCORE_BUSY, oCORE_VALID, oCORE_DATA, oMEMORY_REQ, oMEMORY_ORDER, oMEMORY_MASK,
           oMEMORY_RW, oMEMORY_ADDR, oMEMORY_DATA, oMEMORY_LOCK
  );

endinterface

// File: rtl/mist1032sa_mem_tag_fifo.sv
// Read-tag FIFO: one entry per outstanding load, popped as responses return in order.
module mist1032sa_mem_tag_fifo
  import mist1032sa_mem_pkg::*;
#(
  parameter int unsigned P_DEPTH   = 8,
  parameter int unsigned P_DEPTH_N = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  tag_t push_data,
  input  logic pop,
  output tag_t pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned CNT_W = P_DEPTH_N + 1;

  tag_t                 mem_q [P_DEPTH];
  tag_t                 mem_d [P_DEPTH];
  logic [P_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full     = (count_q == CNT_W'(P_DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + P_DEPTH_N'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + P_DEPTH_N'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(P_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mist1032sa_mem_access_master.sv
// Load/store initiator: core requests become masked memory beats; read responses
// are matched to in-order tags, extracted, extended and registered back to the core.
module mist1032sa_mem_access_master
  import mist1032sa_mem_pkg::*;
#(
  parameter int unsigned P_TAG_DEPTH   = 8,
  parameter int unsigned P_TAG_DEPTH_N = 3
) (
  input  logic                           iCLOCK,
  input  logic                           inRESET,
  mist1032sa_mem_access_master_if.master bus,
  output logic                           oERROR
);

  logic              req_vld_q, req_vld_d;
  logic [1:0]        req_order_q, req_order_d;
  logic              req_rw_q, req_rw_d;
  logic              req_sgn_q, req_sgn_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [MASK_W-1:0] req_mask_q, req_mask_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              res_vld_q, res_vld_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              err_q, err_d;

  logic lock_c, resp_fire_c, issue_c, busy_c, accept_c;
  logic tag_push, tag_pop, tag_full, tag_empty;
  tag_t tag_din, tag_dout;

  mist1032sa_mem_tag_fifo #(
    .P_DEPTH   (P_TAG_DEPTH),
    .P_DEPTH_N (P_TAG_DEPTH_N)
  ) u_tag_fifo (
    .clk       (iCLOCK),
    .rst_n     (inRESET),
    .push      (tag_push),
    .push_data (tag_din),
    .pop       (tag_pop),
    .pop_data  (tag_dout),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_comb begin
    // Responses offered while the core back-pressures are not taken.
    lock_c      = res_vld_q && bus.iCORE_BUSY;
    resp_fire_c = bus.iMEMORY_VALID && !lock_c;
    tag_pop     = resp_fire_c && !tag_empty;
    issue_c     = req_vld_q && !bus.iMEMORY_LOCK && !(!req_rw_q && tag_full && !tag_pop);
    busy_c      = req_vld_q && !issue_c;
    accept_c    = bus.iCORE_REQ && !busy_c;
    tag_push    = issue_c && !req_rw_q;
    tag_din     = tag_t'{addr: req_addr_q[2:0], order: req_order_q, sgn: req_sgn_q};

    req_vld_d   = req_vld_q && !issue_c;
    req_order_d = req_order_q;
    req_rw_d    = req_rw_q;
    req_sgn_d   = req_sgn_q;
    req_addr_d  = req_addr_q;
    req_mask_d  = req_mask_q;
    req_data_d  = req_data_q;

    // ORDER_NONE is accepted but never enters the stage.
    if (accept_c && bus.iCORE_ORDER != ORDER_NONE) begin
      req_vld_d   = 1'b1;
      req_order_d = bus.iCORE_ORDER;
      req_rw_d    = bus.iCORE_RW;
      req_sgn_d   = bus.iCORE_SIGNED;
      case (bus.iCORE_ORDER)
        ORDER_BYTE: begin
          req_addr_d = bus.iCORE_ADDR;
          req_mask_d = MASK_W'(4'b0001 << bus.iCORE_ADDR[1:0]);
          req_data_d = {4{bus.iCORE_DATA[7:0]}};
        end
        ORDER_HALF: begin
          req_addr_d = {bus.iCORE_ADDR[ADDR_W-1:1], 1'b0};
          req_mask_d = bus.iCORE_ADDR[1] ? 4'b1100 : 4'b0011;
          req_data_d = {2{bus.iCORE_DATA[15:0]}};
        end
        default: begin
          req_addr_d = {bus.iCORE_ADDR[ADDR_W-1:2], 2'b00};
          req_mask_d = 4'b1111;
          req_data_d = bus.iCORE_DATA;
        end
      endcase
    end

    res_vld_d  = res_vld_q && bus.iCORE_BUSY;
    res_data_d = res_data_q;
    if (tag_pop) begin
      res_vld_d  = 1'b1;
      res_data_d = extract_load(bus.iMEMORY_DATA, tag_dout);
    end

    err_d = err_q || (resp_fire_c && tag_empty);
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      req_vld_q   <= 1'b0;
      req_order_q <= '0;
      req_rw_q    <= 1'b0;
      req_sgn_q   <= 1'b0;
      req_addr_q  <= '0;
      req_mask_q  <= '0;
      req_data_q  <= '0;
      res_vld_q   <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      req_vld_q   <= req_vld_d;
      req_order_q <= req_order_d;
      req_rw_q    <= req_rw_d;
      req_sgn_q   <= req_sgn_d;
      req_addr_q  <= req_addr_d;
      req_mask_q  <= req_mask_d;
      req_data_q  <= req_data_d;
      res_vld_q   <= res_vld_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.oCORE_BUSY    = busy_c;
  assign bus.oCORE_VALID   = res_vld_q;
  assign bus.oCORE_DATA    = res_data_q;
  assign bus.oMEMORY_REQ   = req_vld_q;
  assign bus.oMEMORY_ORDER = req_order_q;
  assign bus.oMEMORY_MASK  = req_mask_q;
  assign bus.oMEMORY_RW    = req_rw_q;
  assign bus.oMEMORY_ADDR  = req_addr_q;
  assign bus.oMEMORY_DATA  = req_data_q;
  assign bus.oMEMORY_LOCK  = lock_c;
  assign oERROR            = err_q;

endmodule

// File: tb/tb_mist1032sa_mem_access_master.sv
// Directed bench for the access master: store beats, load extraction, lock stalls,
// tag-full stall, result hold and the no-tag error flag.
module tb_mist1032sa_mem_access_master;
  import mist1032sa_mem_pkg::*;

  logic clk;
  logic rst_n;
  logic err;
  int   n_checks;
  int   n_errors;

  mist1032sa_mem_access_master_if bus ();

  mist1032sa_mem_access_master dut (
    .iCLOCK  (clk),
    .inRESET (rst_n),
    .bus     (bus),
    .oERROR  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request for a single cycle; returns at the negedge after acceptance.
  task automatic send(input logic [1:0] order, input logic rw, input logic sgn,
                      input logic [25:0] addr, input logic [31:0] data);
    bus.iCORE_REQ    = 1'b1;
    bus.iCORE_ORDER  = order;
    bus.iCORE_RW     = rw;
    bus.iCORE_SIGNED = sgn;
    bus.iCORE_ADDR   = addr;
    bus.iCORE_DATA   = data;
    @(negedge clk);
    bus.iCORE_REQ    = 1'b0;
  endtask

  // One-cycle read response pulse; returns at the negedge where the result is visible.
  task automatic respond(input logic [63:0] line);
    bus.iMEMORY_VALID = 1'b1;
    bus.iMEMORY_DATA  = line;
    @(negedge clk);
    bus.iMEMORY_VALID = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.iCORE_REQ = 1'b0;  bus.iCORE_ORDER = 2'b00; bus.iCORE_RW = 1'b0;
    bus.iCORE_SIGNED = 1'b0; bus.iCORE_ADDR = '0; bus.iCORE_DATA = '0;
    bus.iCORE_BUSY = 1'b0; bus.iMEMORY_LOCK = 1'b0; bus.iMEMORY_VALID = 1'b0;
    bus.iMEMORY_DATA = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req",   64'(bus.oMEMORY_REQ), 64'd0);
    check("rst_busy",  64'(bus.oCORE_BUSY),  64'd0);
    check("rst_valid", 64'(bus.oCORE_VALID), 64'd0);
    check("rst_lock",  64'(bus.oMEMORY_LOCK), 64'd0);
    check("rst_err",   64'(err),              64'd0);

    // Word store
    send(ORDER_WORD, 1'b1, 1'b0, 26'h10, 32'h89ABCDEF);
    check("ws_req",   64'(bus.oMEMORY_REQ),   64'd1);
    check("ws_mask",  64'(bus.oMEMORY_MASK),  64'hF);
    check("ws_addr",  64'(bus.oMEMORY_ADDR),  64'h10);
    check("ws_rw",    64'(bus.oMEMORY_RW),    64'd1);
    check("ws_data",  64'(bus.oMEMORY_DATA),  64'h89ABCDEF);
    check("ws_order", 64'(bus.oMEMORY_ORDER), 64'h2);
    @(negedge clk);
    check("ws_done", 64'(bus.oMEMORY_REQ), 64'd0);

    // Half store at odd address, byte store at lane 2
    send(ORDER_HALF, 1'b1, 1'b0, 26'h3, 32'hFFFF1234);
    check("hs_mask", 64'(bus.oMEMORY_MASK), 64'hC);
    check("hs_addr", 64'(bus.oMEMORY_ADDR), 64'h2);
    check("hs_data", 64'(bus.oMEMORY_DATA), 64'h12341234);
    send(ORDER_BYTE, 1'b1, 1'b0, 26'h2, 32'h000000A5);
    check("bs_mask", 64'(bus.oMEMORY_MASK), 64'h4);
    check("bs_addr", 64'(bus.oMEMORY_ADDR), 64'h2);
    check("bs_data", 64'(bus.oMEMORY_DATA), 64'hA5A5A5A5);
    @(negedge clk);

    // Order none is swallowed
    send(ORDER_NONE, 1'b0, 1'b0, 26'h40, 32'h0);
    check("none_req", 64'(bus.oMEMORY_REQ), 64'd0);

    // Byte loads signed / unsigned from the upper word, lane 1
    send(ORDER_BYTE, 1'b0, 1'b1, 26'h5, 32'h0);
    check("bl_mask", 64'(bus.oMEMORY_MASK), 64'h2);
    check("bl_rw",   64'(bus.oMEMORY_RW),   64'd0);
    @(negedge clk);
    respond(64'h0000_8000_0000_0000);
    check("bl_s_valid", 64'(bus.oCORE_VALID), 64'd1);
    check("bl_s_data",  64'(bus.oCORE_DATA),  64'hFFFFFF80);
    @(negedge clk);
    check("bl_s_drop", 64'(bus.oCORE_VALID), 64'd0);
    send(ORDER_BYTE, 1'b0, 1'b0, 26'h5, 32'h0);
    @(negedge clk);
    respond(64'h0000_8000_0000_0000);
    check("bl_u_data", 64'(bus.oCORE_DATA), 64'h00000080);
    // Signed half, upper lane of the low word
    send(ORDER_HALF, 1'b0, 1'b1, 26'h2, 32'h0);
    @(negedge clk);
    respond(64'h1111_2222_9ABC_0000);
    check("hl_s_data", 64'(bus.oCORE_DATA), 64'hFFFF9ABC);
    @(negedge clk);

    // Memory lock holds the beat for five cycles
    bus.iMEMORY_LOCK = 1'b1;
    send(ORDER_WORD, 1'b1, 1'b0, 26'h20, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("lk_req%0d", i),  64'(bus.oMEMORY_REQ),  64'd1);
      check($sformatf("lk_busy%0d", i), 64'(bus.oCORE_BUSY),   64'd1);
      check($sformatf("lk_data%0d", i), 64'(bus.oMEMORY_DATA), 64'hCAFEF00D);
      @(negedge clk);
    end
    bus.iMEMORY_LOCK = 1'b0;
    #1;
    check("lk_free_busy", 64'(bus.oCORE_BUSY), 64'd0);
    @(negedge clk);
    check("lk_issued", 64'(bus.oMEMORY_REQ), 64'd0);

    // Nine reads: eight fill the tag FIFO, the ninth waits for a response
    for (int i = 0; i < 9; i++) send(ORDER_WORD, 1'b0, 1'b0, 26'(i * 4), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("tf_req%0d", i),  64'(bus.oMEMORY_REQ),  64'd1);
      check($sformatf("tf_busy%0d", i), 64'(bus.oCORE_BUSY),   64'd1);
      check($sformatf("tf_addr%0d", i), 64'(bus.oMEMORY_ADDR), 64'h20);
      @(negedge clk);
    end
    bus.iMEMORY_VALID = 1'b1;
    bus.iMEMORY_DATA  = {32'hA000_0000, 32'hB000_0000};
    #1;
    check("tf_free_busy", 64'(bus.oCORE_BUSY), 64'd0);
    @(negedge clk);
    bus.iMEMORY_VALID = 1'b0;
    check("tf_issued", 64'(bus.oMEMORY_REQ), 64'd0);
    check("tf_r0",     64'(bus.oCORE_DATA),  64'hB0000000);
    for (int k = 1; k < 9; k++) begin
      respond({32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k)});
      check($sformatf("tf_r%0d", k), 64'(bus.oCORE_DATA),
            (k % 2 == 1) ? 64'(32'hA000_0000 + 32'(k)) : 64'(32'hB000_0000 + 32'(k)));
    end
    check("tf_noerr", 64'(err), 64'd0);

    // Result hold under core back-pressure
    send(ORDER_WORD, 1'b0, 1'b0, 26'h0, 32'h0);
    @(negedge clk);
    bus.iCORE_BUSY = 1'b1;
    respond({32'h0, 32'h11112222});
    check("hold_valid", 64'(bus.oCORE_VALID),  64'd1);
    check("hold_lock",  64'(bus.oMEMORY_LOCK), 64'd1);
    respond({32'h0, 32'h33334444});
    check("hold_data",  64'(bus.oCORE_DATA),   64'h11112222);
    check("hold_noerr", 64'(err),              64'd0);
    bus.iCORE_BUSY = 1'b0;
    #1;
    check("hold_unlock", 64'(bus.oMEMORY_LOCK), 64'd0);
    @(negedge clk);
    check("hold_drop", 64'(bus.oCORE_VALID), 64'd0);

    // Stray response with no tag outstanding
    respond({32'h0, 32'h55556666});
    check("err_set",   64'(err),             64'd1);
    check("err_noval", 64'(bus.oCORE_VALID), 64'd0);
    @(negedge clk);
    check("err_sticky", 64'(err), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("err_clear", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
